// File: rtl/run_control_input_pkg.sv
// run_control_input_pkg: shared run-state and phase types for the
// switch-side run controller (no ports; imported by the rtl files).
package run_control_input_pkg;

  typedef enum logic [1:0] {
    RS_RESET = 2'd0,
    RS_HALT  = 2'd1,
    RS_RUN   = 2'd2,
    RS_STEP  = 2'd3
  } run_state_t;

  typedef logic [1:0] phase_t;

  localparam int HOLD_W = 8;
  typedef logic [HOLD_W-1:0] hold_t;

endpackage

// File: rtl/run_control_input_switch_debouncer.sv
// switch_debouncer: 2-FF sync, debounce filter, rising-edge pulse.
// Ports: clk, rst_n (async low), raw in; level (filtered), rise (1-cycle).
module switch_debouncer
  import run_control_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic level_prev;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        // this sample is the Nth differing one in a row
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/run_control_input.sv
// run_control_input: debounced run/halt/step/clear control for the core.
// Ports: clkBase, rst (async low), sigCH/sigCE/sigCP in; cpuClkEn, cpuRst, running, phase out.
module run_control_input
  import run_control_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20,
  parameter int CLK_DIV         = 4,
  parameter int RST_HOLD        = 4
) (
  input  logic       clkBase,
  input  logic       rst,
  input  logic       sigCH,
  input  logic       sigCE,
  input  logic       sigCP,
  output logic       cpuClkEn,
  output logic       cpuRst,
  output logic       running,
  output logic [1:0] phase
);

  localparam phase_t PHASE_LAST = phase_t'(CLK_DIV - 1);
  localparam hold_t  HOLD_LAST  = hold_t'(RST_HOLD - 1);

  logic ch_level;
  logic ch_rise;
  logic ce_level;
  logic ce_edge;
  logic cp_level;
  logic cp_edge;
  logic unused_ok;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_ch (
    .clk  (clkBase),
    .rst_n(rst),
    .raw  (sigCH),
    .level(ch_level),
    .rise (ch_rise)
  );

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_ce (
    .clk  (clkBase),
    .rst_n(rst),
    .raw  (sigCE),
    .level(ce_level),
    .rise (ce_edge)
  );

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_cp (
    .clk  (clkBase),
    .rst_n(rst),
    .raw  (sigCP),
    .level(cp_level),
    .rise (cp_edge)
  );

  assign unused_ok = ^{ch_rise, ce_level, cp_level};

  run_state_t state;
  run_state_t state_next;
  hold_t      hold;
  hold_t      hold_next;
  phase_t     phase_next;
  logic       clk_en_next;
  logic       cpu_rst_next;
  logic       running_next;

  always_ff @(posedge clkBase or negedge rst) begin
    if (!rst) begin
      state    <= RS_RESET;
      hold     <= '0;
      phase    <= '0;
      cpuClkEn <= 1'b0;
      cpuRst   <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_next;
      hold     <= hold_next;
      phase    <= phase_next;
      cpuClkEn <= clk_en_next;
      cpuRst   <= cpu_rst_next;
      running  <= running_next;
    end
  end

  always_comb begin
    state_next   = state;
    hold_next    = hold;
    phase_next   = '0;
    clk_en_next  = 1'b0;
    cpu_rst_next = 1'b1;
    unique case (state)
      RS_RESET: begin
        cpu_rst_next = 1'b0;
        if (ce_edge) begin
          hold_next = '0;
        end else if (hold == HOLD_LAST) begin
          state_next   = RS_HALT;
          hold_next    = '0;
          cpu_rst_next = 1'b1;
        end else begin
          hold_next = hold + 1'b1;
        end
      end
      RS_HALT: begin
        if (ce_edge) begin
          state_next   = RS_RESET;
          hold_next    = '0;
          cpu_rst_next = 1'b0;
        end else if (ch_level) begin
          state_next = RS_RUN;
        end else if (cp_edge) begin
          state_next = RS_STEP;
        end
      end
      RS_RUN, RS_STEP: begin
        if (ce_edge) begin
          state_next   = RS_RESET;
          hold_next    = '0;
          cpu_rst_next = 1'b0;
        end else if (phase == PHASE_LAST) begin
          // period boundary: the only point where the core may stop
          if (state == RS_STEP || !ch_level) begin
            state_next = RS_HALT;
          end
        end else begin
          phase_next  = phase + 1'b1;
          clk_en_next = (phase_next == PHASE_LAST);
        end
      end
      default: begin
        state_next   = RS_RESET;
        hold_next    = '0;
        cpu_rst_next = 1'b0;
      end
    endcase
    running_next = (state_next == RS_RUN) ||
                   (state_next == RS_STEP);
  end

endmodule

// File: tb/tb_run_control_input.sv
// tb_run_control_input: randomized scenarios checked against a
// behavioural model of the switch conditioner and run controller.
module tb_run_control_input;

  localparam int DEB  = 4;
  localparam int DIV  = 4;
  localparam int HOLD = 4;

  localparam int M_RESET = 0;
  localparam int M_HALT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_STEP  = 3;

  logic clkBase = 1'b0;
  logic rst     = 1'b1;
  logic sigCH   = 1'b0;
  logic sigCE   = 1'b0;
  logic sigCP   = 1'b0;
  logic cpuClkEn;
  logic cpuRst;
  logic running;
  logic [1:0] phase;
  logic [4:0] dut_out;

  int passed = 0;
  int total  = 0;

  run_control_input #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (20),
    .CLK_DIV        (DIV),
    .RST_HOLD       (HOLD)
  ) dut (
    .clkBase (clkBase),
    .rst     (rst),
    .sigCH   (sigCH),
    .sigCE   (sigCE),
    .sigCP   (sigCP),
    .cpuClkEn(cpuClkEn),
    .cpuRst  (cpuRst),
    .running (running),
    .phase   (phase)
  );

  always #5 clkBase = ~clkBase;

  assign dut_out = {cpuRst, running, cpuClkEn, phase};

  // model: mode, cycles spent in reset, cycles since run/step entry
  int m_mode = M_RESET;
  int m_low  = 1;
  int m_age  = 0;
  bit q1 [3];
  bit q2 [3];
  bit db [3];
  bit dbp [3];
  bit [DEB-1:0] win [3];

  always @(posedge clkBase or negedge rst) begin
    if (!rst) begin
      m_mode = M_RESET;
      m_low  = 1;
      m_age  = 0;
      for (int i = 0; i < 3; i++) begin
        q1[i] = 0; q2[i] = 0; db[i] = 0; dbp[i] = 0; win[i] = '0;
      end
    end else begin
      bit [2:0] raw;
      bit ch, ce_e, cp_e;
      raw  = {sigCP, sigCE, sigCH};
      ch   = db[0];
      ce_e = db[1] && !dbp[1];
      cp_e = db[2] && !dbp[2];
      case (m_mode)
        M_RESET: begin
          if (ce_e) m_low = 1;
          else if (m_low == HOLD) m_mode = M_HALT;
          else m_low++;
        end
        M_HALT: begin
          if (ce_e) begin m_mode = M_RESET; m_low = 1; end
          else if (ch) begin m_mode = M_RUN; m_age = 0; end
          else if (cp_e) begin m_mode = M_STEP; m_age = 0; end
        end
        default: begin
          if (ce_e) begin m_mode = M_RESET; m_low = 1; end
          else if ((m_age % DIV == DIV - 1) && (m_mode == M_STEP || !ch))
            m_mode = M_HALT;
          else m_age++;
        end
      endcase
      // level flips after DEB synced samples in a row disagree with it
      for (int i = 0; i < 3; i++) begin
        dbp[i] = db[i];
        win[i] = {win[i][DEB-2:0], q2[i]};
        if (win[i] == {DEB{~db[i]}}) db[i] = ~db[i];
        q2[i] = q1[i];
        q1[i] = raw[i];
      end
    end
  end

  function automatic logic [4:0] exp_out();
    logic act;
    logic [1:0] ph;
    act = (m_mode == M_RUN) || (m_mode == M_STEP);
    ph  = act ? 2'(m_age % DIV) : 2'd0;
    return {m_mode != M_RESET, act, act && (m_age % DIV == DIV - 1), ph};
  endfunction

  task automatic test_reset();
    int low;
    rst = 0; sigCH = 0; sigCE = 0; sigCP = 0;
    repeat (3) begin
      @(negedge clkBase);
      total++;
      if (dut_out !== 5'b0)
        $display("FAIL reset_values: got %b exp 00000", dut_out);
      else passed++;
    end
    rst = 1;
    #1;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dut_out !== exp_out())
        $display("FAIL reset_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (cpuRst === 1'b0) low++;
      @(negedge clkBase);
    end
    total++;
    if (low != HOLD)
      $display("FAIL reset_low_len: got %0d exp %0d", low, HOLD);
    else passed++;
  endtask

  task automatic test_glitch();
    int strobes, run_cyc, len;
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, DEB - 1);
      sigCP = 1;
      for (int i = 0; i < len + 14; i++) begin
        if (i == len) sigCP = 0;
        @(negedge clkBase);
        total++;
        if (dut_out !== exp_out())
          $display("FAIL glitch_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
        else passed++;
        if (cpuClkEn === 1'b1 || running === 1'b1) strobes++;
      end
    end
    total++;
    if (strobes != 0)
      $display("FAIL glitch_filtered: got %0d active cycles exp 0", strobes);
    else passed++;
    strobes = 0;
    run_cyc = 0;
    sigCP = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) sigCP = 0;
      @(negedge clkBase);
      total++;
      if (dut_out !== exp_out())
        $display("FAIL step_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (cpuClkEn === 1'b1) strobes++;
      if (running === 1'b1) run_cyc++;
    end
    total++;
    if (strobes != 1)
      $display("FAIL step_strobes: got %0d exp 1", strobes);
    else passed++;
    total++;
    if (run_cyc != DIV)
      $display("FAIL step_running: got %0d exp %0d", run_cyc, DIV);
    else passed++;
    total++;
    if (dut_out !== 5'b10000)
      $display("FAIL step_halt: got %b exp 10000", dut_out);
    else passed++;
  endtask

  task automatic test_run();
    int wait_cyc, strobes;
    bit seen;
    sigCH = 1;
    seen = 0;
    wait_cyc = 0;
    while (!seen && wait_cyc < 30) begin
      @(negedge clkBase);
      wait_cyc++;
      total++;
      if (dut_out !== exp_out())
        $display("FAIL run_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (cpuClkEn === 1'b1) seen = 1;
    end
    total++;
    if (!seen || wait_cyc > 2 + DEB + 10)
      $display("FAIL run_first_strobe: got %0d cycles seen=%0d exp <=%0d", wait_cyc, seen, 2 + DEB + 10);
    else passed++;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkBase);
      total++;
      if (dut_out !== exp_out())
        $display("FAIL run_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (cpuClkEn === 1'b1) begin
        strobes++;
        total++;
        if (phase !== 2'(DIV - 1))
          $display("FAIL run_strobe_phase: got %0d exp %0d", phase, DIV - 1);
        else passed++;
      end
    end
    total++;
    if (strobes != 100 / DIV)
      $display("FAIL run_strobe_count: got %0d exp %0d", strobes, 100 / DIV);
    else passed++;
  endtask

  task automatic test_halt();
    bit prev_en, fell;
    int late;
    repeat ($urandom_range(0, 3)) @(negedge clkBase);
    sigCH = 0;
    prev_en = 0;
    fell = 0;
    late = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkBase);
      total++;
      if (dut_out !== exp_out())
        $display("FAIL halt_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (fell && cpuClkEn === 1'b1) late++;
      if (!fell && running === 1'b0) begin
        fell = 1;
        total++;
        if (!prev_en || phase !== 2'd0)
          $display("FAIL halt_boundary: got prev_en=%0d phase=%0d exp 1 0", prev_en, phase);
        else passed++;
      end
      prev_en = cpuClkEn;
    end
    total++;
    if (!fell || late != 0)
      $display("FAIL halt_quiet: got fell=%0d late=%0d exp 1 0", fell, late);
    else passed++;
  endtask

  task automatic test_clear_beats_step();
    bit got, fell;
    int n, low, strobes, bad;
    sigCH = 1;
    got = 0;
    n = 0;
    while (!got && n < 30) begin
      @(negedge clkBase);
      n++;
      total++;
      if (dut_out !== exp_out())
        $display("FAIL clear_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (running === 1'b1) got = 1;
    end
    total++;
    if (!got) $display("FAIL clear_enter_run: got running=0 exp 1");
    else passed++;
    repeat ($urandom_range(0, 7)) @(negedge clkBase);
    sigCE = 1; sigCP = 1; sigCH = 0;
    fell = 0; low = 0; strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkBase);
      total++;
      if (dut_out !== exp_out())
        $display("FAIL clear_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (cpuRst === 1'b0) begin fell = 1; low++; end
      if (fell && cpuClkEn === 1'b1) strobes++;
    end
    total++;
    if (low != HOLD)
      $display("FAIL clear_low_len: got %0d exp %0d", low, HOLD);
    else passed++;
    total++;
    if (strobes != 0)
      $display("FAIL clear_strobes: got %0d exp 0", strobes);
    else passed++;
    total++;
    if (dut_out !== 5'b10000)
      $display("FAIL clear_halt: got %b exp 10000", dut_out);
    else passed++;
    sigCE = 0; sigCP = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkBase);
      if (running !== 1'b0 || cpuClkEn !== 1'b0) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL clear_no_step: got %0d active cycles exp 0", bad);
    else passed++;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      sigCH = 1'($urandom_range(0, 1));
      sigCP = 1'($urandom_range(0, 1));
      sigCE = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) begin
        @(negedge clkBase);
        total++;
        if (dut_out !== exp_out())
          $display("FAIL random_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit got;
    int n;
    sigCE = 0; sigCP = 0; sigCH = 1;
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clkBase);
      n++;
      total++;
      if (dut_out !== exp_out())
        $display("FAIL async_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
      if (running === 1'b1 && phase === 2'd2) got = 1;
    end
    total++;
    if (!got) $display("FAIL async_reach_phase2: got running=%0d phase=%0d", running, phase);
    else passed++;
    #2;
    rst = 0;
    #1;
    total++;
    if (dut_out !== 5'b0)
      $display("FAIL async_immediate: got %b exp 00000", dut_out);
    else passed++;
    @(negedge clkBase);
    sigCH = 0;
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clkBase);
      total++;
      if (dut_out !== exp_out())
        $display("FAIL async_model: got %b exp %b t=%0t", dut_out, exp_out(), $time);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_run();
    test_halt();
    test_clear_beats_step();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
